matmul_sequencer: RTL

Command-driven controller for the matmul control datapath. It replaces direct processor toggling of load/write/en. It accepts one command at a time from the PS over a valid/ready handshake and drives the datapath mode pins with the correct encoding and dwell times. It returns read data over a response channel and raises int_to_ps when a RUN (load + matmul) completes. It sits between the PS-facing register/GPIO layer and the control datapath instance.

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/seq_dwell_counter.sv | 37 +++
 rtl/matmul_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and mode-pin encodings for the matmul command sequencer.
package matmul_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_RUN     = 2'd1,
    OP_READ    = 2'd2,
    OP_ILLEGAL = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    LOAD   = 3'd2,
    MATMUL = 3'd3,
    READ   = 3'd4,
    DONE   = 3'd5
  } seq_state_e;

  // Encodings driven on {ctl_load, ctl_write}.
  localparam logic [1:0] MODE_READ   = 2'b11;
  localparam logic [1:0] MODE_WRITE  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_MATMUL = 2'b00;

endpackage

// File: rtl/seq_dwell_counter.sv
// Loadable down-counter timing the dwell of LOAD, MATMUL and READ states.
module seq_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clear_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so a state lingering past terminal count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/matmul_sequencer.sv
// Command-driven sequencer that drives the matmul datapath mode pins with the
// right dwell times and returns read data / completion interrupts to the PS.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int LOAD_CYCLES  = 5,
  parameter int MM_CYCLES    = 12,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_reg_select,
  input  logic [1:0] cmd_idx,
  input  logic [7:0] cmd_data,
  input  logic       abort,
  output logic       ctl_en,
  output logic       ctl_load,
  output logic       ctl_write,
  output logic [2:0] ctl_reg_select,
  output logic [1:0] ctl_idx,
  output logic [7:0] ctl_data_in,
  input  logic [7:0] ctl_data_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       int_to_ps,
  output logic       busy,
  output logic       err,
  output logic [3:0] mode_led
);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MM_LAST   = CNT_W'(MM_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_LATENCY - 1);

  seq_state_e       state_q, state_d;
  logic [2:0]       sel_q;
  logic [1:0]       idx_q;
  logic [7:0]       data_q, rsp_data_q;
  logic             rsp_valid_q, int_q, err_q;
  logic             accept, cnt_load, cnt_clear, cnt_tc, rsp_capture, int_set;
  logic [CNT_W-1:0] cnt_val;
  logic [1:0]       mode;
  cmd_op_e          op;

  // Handshake: a command transfers on any cycle where cmd_valid && cmd_ready;
  // cmd_ready depends only on state, never on cmd_valid, and nothing is queued.
  assign op     = cmd_op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    ctl_en      = 1'b0;
    mode        = MODE_READ;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_clear   = 1'b0;
    rsp_capture = 1'b0;
    int_set     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_WRITE: state_d = WRITE;
            OP_RUN: begin
              state_d  = LOAD;
              cnt_load = 1'b1;
              cnt_val  = LOAD_LAST;
            end
            OP_READ: begin
              state_d  = READ;
              cnt_load = 1'b1;
              cnt_val  = READ_LAST;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      WRITE: begin
        ctl_en  = 1'b1;
        mode    = MODE_WRITE;
        state_d = IDLE;
      end
      LOAD: begin
        ctl_en = 1'b1;
        mode   = MODE_LOAD;
        if (abort) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (cnt_tc) begin
          state_d  = MATMUL;
          cnt_load = 1'b1;
          cnt_val  = MM_LAST;
        end
      end
      MATMUL: begin
        ctl_en = 1'b1;
        mode   = MODE_MATMUL;
        if (abort) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (cnt_tc) begin
          state_d = DONE;
        end
      end
      READ: begin
        ctl_en = 1'b1;
        if (abort) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (cnt_tc) begin
          state_d     = IDLE;
          rsp_capture = 1'b1;
        end
      end
      DONE: begin
        int_set = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      int_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_capture;
      if (rsp_capture) rsp_data_q <= ctl_data_out;
      if (accept) begin
        sel_q  <= cmd_reg_select;
        idx_q  <= cmd_idx;
        data_q <= cmd_data;
        err_q  <= (op == OP_ILLEGAL);
        int_q  <= 1'b0;
      end else if (int_set) begin
        int_q <= 1'b1;
      end
    end
  end

  seq_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .clear_i    (cnt_clear),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    case ({ctl_load, ctl_write})
      MODE_READ:  mode_led = 4'b0001;
      MODE_WRITE: mode_led = 4'b0010;
      MODE_LOAD:  mode_led = 4'b0100;
      default:    mode_led = 4'b1000;
    endcase
  end

  assign {ctl_load, ctl_write} = mode;
  assign ctl_reg_select        = sel_q;
  assign ctl_idx               = idx_q;
  assign ctl_data_in           = data_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_data              = rsp_data_q;
  assign int_to_ps             = int_q;
  assign err                   = err_q;
  assign busy                  = (state_q != IDLE);

endmodule
